// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit control for a 5-stage MIPS-style pipeline.
// This block owns the architectural HI/LO registers and sequences MULT/MULTU
// (5 busy cycles) and DIV/DIVU (10 busy cycles). It also handles MTHI/MTLO,
// which complete in a single cycle. The stall output holds an MDU instruction
// in D while the unit is busy, or while an MDU operation is starting in E.
module mdu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  localparam logic [3:0] MUL_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES = 4'd10;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        sgn_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] res_hi_d;
  logic [31:0] res_lo_d;

  // Result datapath, fed only by the latched operands. Signed division runs
  // on magnitudes and then fixes the signs. With this approach,
  // 0x80000000 / -1 wraps to 0x80000000 with a zero remainder.
  always_comb begin
    ext_a    = sgn_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    ext_b    = sgn_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    prod     = ext_a * ext_b;
    a_mag    = (sgn_q && a_q[31]) ? (32'd0 - a_q) : a_q;
    b_mag    = (sgn_q && b_q[31]) ? (32'd0 - b_q) : b_q;
    b_safe   = (b_mag == '0) ? 32'd1 : b_mag;
    q_mag    = a_mag / b_safe;
    r_mag    = a_mag % b_safe;
    quo      = (sgn_q && (a_q[31] ^ b_q[31])) ? (32'd0 - q_mag) : q_mag;
    rem      = (sgn_q && a_q[31]) ? (32'd0 - r_mag) : r_mag;
    res_hi_d = hi_q;
    res_lo_d = lo_q;
    if (state_q == MUL) begin
      res_hi_d = prod[63:32];
      res_lo_d = prod[31:0];
    end else if (state_q == DIV && b_q != '0) begin
      res_hi_d = rem;
      res_lo_d = quo;
    end
  end

  // Control FSM: latches operands on start and counts down the busy window.
  // At the final count, it commits HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1: begin
                a_q     <= rs_val;
                b_q     <= rt_val;
                sgn_q   <= (op == 3'd0);
                cnt_q   <= MUL_CYCLES;
                state_q <= MUL;
              end
              3'd2, 3'd3: begin
                a_q     <= rs_val;
                b_q     <= rt_val;
                sgn_q   <= (op == 3'd2);
                cnt_q   <= DIV_CYCLES;
                state_q <= DIV;
              end
              3'd4:    hi_q <= rs_val;
              3'd5:    lo_q <= rs_val;
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            hi_q    <= res_hi_d;
            lo_q    <= res_lo_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Busy reflects the state register; stall is the combinational hazard term.
  always_comb begin
    busy  = (state_q != IDLE);
    stall = d_md_use && (busy || (start && op <= 3'd3));
    hi    = hi_q;
    lo    = lo_q;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Testbench for mdu_ctrl.
// Stimulus pushes the expected HI/LO results and the expected busy length
// into a scoreboard queue. A separate monitor pops and compares each entry
// when busy falls.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .d_md_use (d_md_use),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ph;
    logic [31:0] pl;
    logic [31:0] eh;
    logic [31:0] el;
    int unsigned len;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        mon_en = 1'b0;
  logic        abort_pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 5)
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: checks that HI/LO hold during busy, then checks each result and
  // the busy length as busy falls.
  initial begin
    logic        busy_prev;
    int unsigned blen;
    exp_t        e;
    busy_prev = 1'b0;
    blen      = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (busy === 1'b1) begin
          blen++;
          if (sb.size() > 0) begin
            check("hold_hi", hi, sb[0].ph);
            check("hold_lo", lo, sb[0].pl);
          end
        end else if (busy_prev) begin
          if (abort_pending) begin
            check("abort_hi", hi, 32'h0);
            check("abort_lo", lo, 32'h0);
            check("abort_len", blen, 32'd3);
            if (sb.size() > 0) void'(sb.pop_front());
            abort_pending = 1'b0;
          end else if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_busy: got busy window of %0d, required none", blen);
          end else begin
            e = sb.pop_front();
            check("res_hi", hi, e.eh);
            check("res_lo", lo, e.el);
            check("busy_len", blen, e.len);
          end
          blen = 0;
        end
        busy_prev = (busy === 1'b1);
      end
    end
  end

  // Reference model plus driver for one instruction.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic dmd);
    exp_t           e;
    longint         sa, sbv, p, q, r;
    longint unsigned ua, ubv, up;
    int unsigned    len;
    logic           busy_exp;
    e.ph = m_hi;
    e.pl = m_lo;
    len  = 0;
    sa   = longint'($signed(a));
    sbv  = longint'($signed(b));
    ua   = {32'b0, a};
    ubv  = {32'b0, b};
    case (o)
      3'd0: begin p = sa * sbv; m_hi = p[63:32]; m_lo = p[31:0]; len = 5; end
      3'd1: begin up = ua * ubv; m_hi = up[63:32]; m_lo = up[31:0]; len = 5; end
      3'd2: begin
        if (b != 0) begin q = sa / sbv; r = sa % sbv; m_lo = q[31:0]; m_hi = r[31:0]; end
        len = 10;
      end
      3'd3: begin
        if (b != 0) begin up = ua / ubv; m_lo = up[31:0]; up = ua % ubv; m_hi = up[31:0]; end
        len = 10;
      end
      3'd4:    m_hi = a;
      3'd5:    m_lo = a;
      default: ;
    endcase
    e.eh  = m_hi;
    e.el  = m_lo;
    e.len = len;
    if (len != 0) sb.push_back(e);

    start = 1'b1; op = o; rs_val = a; rt_val = b; d_md_use = dmd;
    #1 check("stall_issue", {31'b0, stall}, {31'b0, dmd && (o <= 3'd3)});
    @(posedge clk); #1;
    if (len == 0) begin
      start = 1'b0;
      #1;
      check("single_busy", {31'b0, busy}, 32'h0);
      check("single_hi", hi, m_hi);
      check("single_lo", lo, m_lo);
    end else begin
      for (int unsigned k = 1; k <= len + 1; k++) begin
        if (k > 1) begin @(posedge clk); #1; end
        busy_exp = (k <= len);
        if (busy_exp) begin
          start  = 1'($urandom);
          op     = 3'($urandom);
          rs_val = $urandom;
          rt_val = $urandom;
        end else begin
          start = 1'b0;
        end
        #1;
        check("busy", {31'b0, busy}, {31'b0, busy_exp});
        check("stall", {31'b0, stall},
              {31'b0, dmd && (busy_exp || (start && op <= 3'd3))});
      end
    end
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; start = 1'b0; op = '0; rs_val = '0; rt_val = '0; d_md_use = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    mon_en = 1'b1;
    @(posedge clk); #1;

    issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_lo", lo, 32'hFFFF_FFFD);
    issue(3'd4, 32'h1234_5678, 32'h0, 1'b1);
    issue(3'd5, 32'h1234_5678, 32'h0, 1'b0);
    issue(3'd3, 32'hDEAD_BEEF, 32'h0, 1'b0);
    check("divz_hi", hi, 32'h1234_5678);
    check("divz_lo", lo, 32'h1234_5678);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("ovf_hi", hi, 32'h0);
    check("ovf_lo", lo, 32'h8000_0000);
    issue(3'd6, 32'hAAAA_AAAA, 32'h5, 1'b1);
    issue(3'd7, 32'h5555_5555, 32'h5, 1'b0);

    // Abort a MULT with reset on its third busy cycle.
    e.ph = m_hi; e.pl = m_lo; e.eh = 32'h0; e.el = 32'h0; e.len = 5;
    sb.push_back(e);
    start = 1'b1; op = 3'd0; rs_val = 32'h0000_1234; rt_val = 32'h0000_5678; d_md_use = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort_pending = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_stall", {31'b0, stall}, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    check("abort_late_hi", hi, 32'h0);
    check("abort_late_lo", lo, 32'h0);

    for (int i = 0; i < 30; i++) begin
      issue(3'($urandom), pick(), pick(), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1 check("sb_drained", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
